// File: rtl/sccb_cfg_sequencer_pkg.sv
// Shared encodings for the SCCB configuration sequencer: FSM states and table word markers.
// Table words are {reg_addr, reg_data}; the upper byte doubles as the command tag.
package sccb_cfg_sequencer_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FETCH,
        ST_DECODE,
        ST_ISSUE,
        ST_RELEASE,
        ST_DELAY,
        ST_DONE,
        ST_FAIL
    } seq_state_t;

    localparam logic [15:0] END_MARK  = 16'hFFFF;
    localparam logic [7:0]  DELAY_TAG = 8'hF0;

    function automatic logic is_delay_word(input logic [15:0] word);
        return word[15:8] == DELAY_TAG;
    endfunction

endpackage

// File: rtl/sccb_cfg_sequencer_clk_gen.sv
// Free-running SCCB bit clock divider with a one-cycle strobe in the middle of the low phase.
// Outputs are registered straight from the next counter value; no backpressure, runs from reset.
module sccb_clk_gen #(
    parameter int CLK_FREQ_HZ  = 50_000_000,
    parameter int SCCB_FREQ_HZ = 100_000
) (
    input  logic clk_i,
    input  logic rst_i,
    output logic sccb_clk_o,
    output logic data_pulse_o
);

    localparam int HALF = CLK_FREQ_HZ / (2 * SCCB_FREQ_HZ);
    localparam int CW   = $clog2(2 * HALF);

    localparam logic [CW-1:0] HALF_C  = CW'(HALF);
    localparam logic [CW-1:0] LAST_C  = CW'(2 * HALF - 1);
    localparam logic [CW-1:0] PULSE_C = CW'(HALF + HALF / 2);
    localparam logic [CW-1:0] ONE_C   = CW'(1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;
    logic          sccb_clk_q;
    logic          pulse_q;

    always_comb begin
        cnt_d = (cnt_q == LAST_C) ? '0 : cnt_q + ONE_C;
    end

    // Output flops track the counter value they are decoded from, so both stay glitch-free.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            cnt_q      <= '0;
            sccb_clk_q <= 1'b1;
            pulse_q    <= 1'b0;
        end else begin
            cnt_q      <= cnt_d;
            sccb_clk_q <= (cnt_d < HALF_C);
            pulse_q    <= (cnt_d == PULSE_C);
        end
    end

    assign sccb_clk_o   = sccb_clk_q;
    assign data_pulse_o = pulse_q;

endmodule

// File: rtl/sccb_cfg_sequencer.sv
// Walks a camera register table from a sync ROM and issues one SCCB write per entry, with retries and ms delays.
// One ROM read cycle per entry; each write holds start_o until done_i and waits for done_i to clear before the next.
module sccb_cfg_sequencer
    import sccb_cfg_sequencer_pkg::*;
#(
    parameter int          CLK_FREQ_HZ  = 50_000_000,
    parameter int          SCCB_FREQ_HZ = 100_000,
    parameter logic [7:0]  DEV_ID       = 8'h42,
    parameter int          ROM_AW       = 6,
    parameter int          MAX_RETRY    = 3
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              cfg_start_i,
    output logic [ROM_AW-1:0] rom_addr_o,
    input  logic [15:0]       rom_data_i,
    output logic              sccb_clk_o,
    output logic              data_pulse_o,
    output logic [7:0]        addr_o,
    output logic [15:0]       data_o,
    output logic              rw_o,
    output logic              start_o,
    input  logic              done_i,
    input  logic              ack_error_i,
    output logic              busy_o,
    output logic              done_o,
    output logic              error_o,
    output logic [ROM_AW-1:0] err_index_o
);

    localparam int TICK = CLK_FREQ_HZ / 1000;
    localparam int TW   = $clog2(TICK + 1);
    localparam int RTW  = (MAX_RETRY < 1) ? 1 : $clog2(MAX_RETRY + 1);

    localparam logic [ROM_AW-1:0] IDX_ONE  = ROM_AW'(1);
    localparam logic [ROM_AW-1:0] IDX_LAST = '1;
    localparam logic [RTW-1:0]    RTY_ONE  = RTW'(1);
    localparam logic [RTW-1:0]    RTY_MAX  = RTW'(MAX_RETRY);
    localparam logic [TW-1:0]     TICK_ONE = TW'(1);
    localparam logic [TW-1:0]     TICK_END = TW'(TICK - 1);
    // Preload absorbs the fetch/decode cycles around a delay entry so the entry lasts close to nn ms.
    localparam logic [TW-1:0]     TICK_PRE = (TICK > 4) ? TW'(3) : '0;

    seq_state_t        state_q, state_d;
    logic [ROM_AW-1:0] index_q, index_d;
    logic [RTW-1:0]    retry_q, retry_d;
    logic [15:0]       data_q, data_d;
    logic              start_q, start_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              error_q, error_d;
    logic [ROM_AW-1:0] err_idx_q, err_idx_d;
    logic [7:0]        ms_q, ms_d;
    logic [TW-1:0]     tick_q, tick_d;
    logic              ack_err_q, ack_err_d;
    logic              cfg_q;
    logic              cfg_rise;

    assign cfg_rise = cfg_start_i & ~cfg_q;

    sccb_clk_gen #(
        .CLK_FREQ_HZ (CLK_FREQ_HZ),
        .SCCB_FREQ_HZ(SCCB_FREQ_HZ)
    ) u_clk_gen (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .sccb_clk_o  (sccb_clk_o),
        .data_pulse_o(data_pulse_o)
    );

    always_comb begin
        state_d   = state_q;
        index_d   = index_q;
        retry_d   = retry_q;
        data_d    = data_q;
        start_d   = start_q;
        busy_d    = busy_q;
        done_d    = done_q;
        error_d   = error_q;
        err_idx_d = err_idx_q;
        ms_d      = ms_q;
        tick_d    = tick_q;
        ack_err_d = ack_err_q;

        case (state_q)
            ST_IDLE: begin
                if (cfg_rise) begin
                    state_d = ST_FETCH;
                    index_d = '0;
                    retry_d = '0;
                    done_d  = 1'b0;
                    error_d = 1'b0;
                    busy_d  = 1'b1;
                end
            end
            ST_FETCH: state_d = ST_DECODE;
            ST_DECODE: begin
                // The last addressable slot is never issued, so a table without a terminator still ends.
                if (rom_data_i == END_MARK || index_q == IDX_LAST) begin
                    state_d = ST_DONE;
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                end else if (is_delay_word(rom_data_i)) begin
                    ms_d    = rom_data_i[7:0];
                    tick_d  = TICK_PRE;
                    state_d = ST_DELAY;
                end else begin
                    data_d  = rom_data_i;
                    start_d = 1'b1;
                    state_d = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                if (done_i) begin
                    ack_err_d = ack_error_i;
                    start_d   = 1'b0;
                    state_d   = ST_RELEASE;
                end
            end
            ST_RELEASE: begin
                if (!done_i) begin
                    if (!ack_err_q) begin
                        index_d = index_q + IDX_ONE;
                        retry_d = '0;
                        state_d = ST_FETCH;
                    end else if (retry_q < RTY_MAX) begin
                        retry_d = retry_q + RTY_ONE;
                        state_d = ST_FETCH;
                    end else begin
                        err_idx_d = index_q;
                        error_d   = 1'b1;
                        done_d    = 1'b1;
                        busy_d    = 1'b0;
                        state_d   = ST_FAIL;
                    end
                end
            end
            ST_DELAY: begin
                if (ms_q == 8'd0) begin
                    index_d = index_q + IDX_ONE;
                    state_d = ST_FETCH;
                end else if (tick_q == TICK_END) begin
                    tick_d = '0;
                    ms_d   = ms_q - 8'd1;
                    if (ms_q == 8'd1) begin
                        index_d = index_q + IDX_ONE;
                        state_d = ST_FETCH;
                    end
                end else begin
                    tick_d = tick_q + TICK_ONE;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            ST_FAIL: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q   <= ST_IDLE;
            index_q   <= '0;
            retry_q   <= '0;
            data_q    <= '0;
            start_q   <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            error_q   <= 1'b0;
            err_idx_q <= '0;
            ms_q      <= '0;
            tick_q    <= '0;
            ack_err_q <= 1'b0;
            cfg_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            index_q   <= index_d;
            retry_q   <= retry_d;
            data_q    <= data_d;
            start_q   <= start_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            error_q   <= error_d;
            err_idx_q <= err_idx_d;
            ms_q      <= ms_d;
            tick_q    <= tick_d;
            ack_err_q <= ack_err_d;
            cfg_q     <= cfg_start_i;
        end
    end

    assign rom_addr_o  = index_q;
    assign addr_o      = DEV_ID;
    assign rw_o        = 1'b1;
    assign data_o      = data_q;
    assign start_o     = start_q;
    assign busy_o      = busy_q;
    assign done_o      = done_q;
    assign error_o     = error_q;
    assign err_index_o = err_idx_q;

endmodule

// File: tb/tb_sccb_cfg_sequencer.sv
// Directed bench: sync ROM model plus a behavioural controller/slave that can NAK chosen entries.
module tb_sccb_cfg_sequencer;

    localparam int ROM_AW = 6;

    logic              clk_i = 1'b0;
    logic              rst_i = 1'b0;
    logic              cfg_start_i = 1'b0;
    logic [ROM_AW-1:0] rom_addr_o;
    logic [15:0]       rom_data_i;
    logic              sccb_clk_o;
    logic              data_pulse_o;
    logic [7:0]        addr_o;
    logic [15:0]       data_o;
    logic              rw_o;
    logic              start_o;
    logic              done_i = 1'b0;
    logic              ack_error_i = 1'b0;
    logic              busy_o;
    logic              done_o;
    logic              error_o;
    logic [ROM_AW-1:0] err_index_o;

    int passed = 0;
    int fails  = 0;
    int total  = 0;

    sccb_cfg_sequencer #(
        .CLK_FREQ_HZ (100_000),
        .SCCB_FREQ_HZ(10_000),
        .DEV_ID      (8'h42),
        .ROM_AW      (ROM_AW),
        .MAX_RETRY   (3)
    ) dut (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .cfg_start_i (cfg_start_i),
        .rom_addr_o  (rom_addr_o),
        .rom_data_i  (rom_data_i),
        .sccb_clk_o  (sccb_clk_o),
        .data_pulse_o(data_pulse_o),
        .addr_o      (addr_o),
        .data_o      (data_o),
        .rw_o        (rw_o),
        .start_o     (start_o),
        .done_i      (done_i),
        .ack_error_i (ack_error_i),
        .busy_o      (busy_o),
        .done_o      (done_o),
        .error_o     (error_o),
        .err_index_o (err_index_o)
    );

    always #5 clk_i = ~clk_i;

    logic [15:0] rom_mem [64];
    always @(posedge clk_i) rom_data_i <= rom_mem[rom_addr_o];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            fails++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Controller + slave: answer after two data pulses, clear done on the first pulse after start drops.
    int          rs = 0;
    int          pulses = 0;
    logic        nak = 1'b0;
    int          nak_idx = -1;
    int          nak_left = 0;
    int          wr_cnt = 0;
    logic [15:0] wr_log [128];
    logic [7:0]  wr_addr [128];

    always @(negedge clk_i) begin
        if (!rst_i) begin
            rs = 0;
            done_i = 1'b0;
            ack_error_i = 1'b0;
        end else begin
            case (rs)
                0: if (start_o) begin
                    if (wr_cnt < 128) begin
                        wr_log[wr_cnt]  = data_o;
                        wr_addr[wr_cnt] = addr_o;
                    end
                    wr_cnt++;
                    nak = 1'b0;
                    if (int'(rom_addr_o) == nak_idx && nak_left > 0) begin
                        nak = 1'b1;
                        nak_left--;
                    end
                    pulses = 0;
                    rs = 1;
                end
                1: if (data_pulse_o) begin
                    pulses++;
                    if (pulses == 2) begin
                        done_i = 1'b1;
                        ack_error_i = nak;
                        rs = 2;
                    end
                end
                2: if (!start_o) rs = 3;
                3: if (data_pulse_o) begin
                    chk("start_low_at_clear", start_o, 1'b0);
                    done_i = 1'b0;
                    ack_error_i = 1'b0;
                    rs = 0;
                end
                default: rs = 0;
            endcase
        end
    end

    task automatic load_rom(input logic [15:0] w0, input logic [15:0] w1,
                            input logic [15:0] w2, input logic [15:0] w3);
        for (int i = 0; i < 64; i++) rom_mem[i] = 16'hFFFF;
        rom_mem[0] = w0;
        rom_mem[1] = w1;
        rom_mem[2] = w2;
        rom_mem[3] = w3;
        wr_cnt = 0;
    endtask

    task automatic kick();
        @(negedge clk_i);
        cfg_start_i = 1'b1;
        @(negedge clk_i);
        cfg_start_i = 1'b0;
    endtask

    task automatic wait_done(input int budget, output int cycles);
        cycles = 0;
        while (done_o !== 1'b1 && cycles < budget) begin
            @(negedge clk_i);
            cycles++;
        end
        chk("done_seen", done_o, 1'b1);
    endtask

    initial begin
        int cyc;
        int n1;
        logic [19:0] got_clk, exp_clk, got_pls, exp_pls;

        repeat (3) @(negedge clk_i);
        chk("rst_start", start_o, 1'b0);
        chk("rst_busy", busy_o, 1'b0);
        chk("rst_done", done_o, 1'b0);
        chk("rst_error", error_o, 1'b0);
        chk("rst_sccb_clk", sccb_clk_o, 1'b1);
        chk("rst_pulse", data_pulse_o, 1'b0);
        chk("rst_rw", rw_o, 1'b1);
        chk("rst_addr", addr_o, 8'h42);
        chk("rst_rom_addr", rom_addr_o, 6'd0);
        chk("rst_data", data_o, 16'h0000);
        chk("rst_err_index", err_index_o, 6'd0);

        // HALF=5: high for c=0..4, pulse at c=7, period 10.
        rst_i = 1'b1;
        for (int j = 0; j < 20; j++) begin
            got_clk[j] = sccb_clk_o;
            got_pls[j] = data_pulse_o;
            exp_clk[j] = ((j % 10) < 5);
            exp_pls[j] = ((j % 10) == 7);
            @(negedge clk_i);
        end
        chk("clkgen_sccb_clk", got_clk, exp_clk);
        chk("clkgen_pulse", got_pls, exp_pls);

        // Two plain writes; a second start while busy must not restart the pass.
        load_rom(16'h1280, 16'h1204, 16'hFFFF, 16'hFFFF);
        kick();
        chk("t1_busy", busy_o, 1'b1);
        repeat (5) @(negedge clk_i);
        cfg_start_i = 1'b1;
        @(negedge clk_i);
        cfg_start_i = 1'b0;
        wait_done(3000, cyc);
        chk("t1_wr_cnt", wr_cnt, 2);
        chk("t1_wr0", wr_log[0], 16'h1280);
        chk("t1_wr1", wr_log[1], 16'h1204);
        chk("t1_dev_id", wr_addr[0], 8'h42);
        chk("t1_error", error_o, 1'b0);
        chk("t1_busy_end", busy_o, 1'b0);

        // 10 ms delay at 100 clks/ms.
        load_rom(16'hF00A, 16'hFFFF, 16'hFFFF, 16'hFFFF);
        kick();
        wait_done(1500, cyc);
        chk("t2_no_bus", wr_cnt, 0);
        chk("t2_delay_window", ((cyc + 1) >= 997 && (cyc + 1) <= 1003), 1'b1);
        chk("t2_error", error_o, 1'b0);

        // Entry 1 NAKed twice then ACKed.
        load_rom(16'h1280, 16'h1204, 16'hFFFF, 16'hFFFF);
        nak_idx = 1;
        nak_left = 2;
        kick();
        wait_done(3000, cyc);
        n1 = 0;
        for (int i = 0; i < wr_cnt && i < 128; i++) if (wr_log[i] == 16'h1204) n1++;
        chk("t3_wr_cnt", wr_cnt, 4);
        chk("t3_entry1_writes", n1, 3);
        chk("t3_error", error_o, 1'b0);

        // Entry 2 always NAKed: 1 + 1 + (MAX_RETRY+1) writes, then failure.
        load_rom(16'h1280, 16'h1204, 16'h1311, 16'hFFFF);
        nak_idx = 2;
        nak_left = 1000;
        kick();
        wait_done(4000, cyc);
        chk("t4_wr_cnt", wr_cnt, 6);
        chk("t4_last_wr", wr_log[5], 16'h1311);
        chk("t4_error", error_o, 1'b1);
        chk("t4_err_index", err_index_o, 6'd2);
        chk("t4_start", start_o, 1'b0);
        chk("t4_busy", busy_o, 1'b0);

        // Reset while a write is outstanding, then a clean rerun from index 0.
        nak_left = 0;
        load_rom(16'h1280, 16'h1204, 16'hFFFF, 16'hFFFF);
        kick();
        cyc = 0;
        while (start_o !== 1'b1 && cyc < 200) begin
            @(negedge clk_i);
            cyc++;
        end
        chk("t5_start_seen", start_o, 1'b1);
        #2 rst_i = 1'b0;
        #1;
        chk("t5_start_async", start_o, 1'b0);
        chk("t5_busy_async", busy_o, 1'b0);
        chk("t5_error_async", error_o, 1'b0);
        repeat (2) @(negedge clk_i);
        rst_i = 1'b1;
        wr_cnt = 0;
        kick();
        wait_done(3000, cyc);
        chk("t5_wr_cnt", wr_cnt, 2);
        chk("t5_wr0", wr_log[0], 16'h1280);

        // Zero-length delay is skipped.
        load_rom(16'hF000, 16'h1234, 16'hFFFF, 16'hFFFF);
        kick();
        wait_done(3000, cyc);
        chk("t6_wr_cnt", wr_cnt, 1);
        chk("t6_wr0", wr_log[0], 16'h1234);

        // No terminator: the last slot (63) acts as the end marker.
        for (int i = 0; i < 64; i++) rom_mem[i] = 16'h2000 + 16'(i);
        wr_cnt = 0;
        kick();
        wait_done(8000, cyc);
        chk("t7_wr_cnt", wr_cnt, 63);
        chk("t7_last_wr", wr_log[62], 16'h203E);
        chk("t7_error", error_o, 1'b0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
